hold_counter: RTL and testbench

Parameterised up-counter with a hold input, used as a latency/delay timer inside the memory models. While enabled, the counter advances by one per clock. While `hold` is high, it freezes at its current value. The parent typically ties `hold` to the all-ones detect of `cntr`, which makes a saturating delay timer whose terminal count marks "access complete". The parent restarts the timer by asserting `reset`.

---
 rtl/hold_counter.sv | 46 ++++
 tb/tb_hold_counter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hold_counter.sv
// hold_counter
// ------------
// Up-counter with a hold input, used as a latency/delay timer inside the
// memory models. The count advances by one on every rising clock edge while
// hold is low and freezes while hold is high. Tying hold to at_max turns it
// into a saturating delay timer whose terminal count (all ones) marks
// "access complete"; the parent restarts the timer by pulsing reset low.
//
// Parameters
//   size    counter width in bits, 1..32 (default 4)
//
// Ports
//   clock   in   rising-edge clock
//   reset   in   asynchronous, active-low; clears cntr
//   hold    in   1 = keep current value, 0 = increment (modulo 2^size)
//   cntr    out  current count, driven straight from the register
//   at_max  out  combinational all-ones decode of cntr
module hold_counter #(
    parameter int size = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            hold,
    output logic [size-1:0] cntr,
    output logic            at_max
);

    // Increment constant sized to the counter so the add wraps naturally
    // at 2^size without any explicit modulo logic.
    localparam logic [size-1:0] step = size'(1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the reset branch is in the sensitivity list,
    // which gives a truly asynchronous clear that beats any simultaneous edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cntr <= '0;
        end else if (!hold) begin
            cntr <= cntr + step;
        end
    end

    // Pure decode, no register stage: at_max tracks cntr in the same cycle.
    assign at_max = &cntr;

endmodule

// File: tb/tb_hold_counter.sv
module tb_hold_counter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // size = 4 instance; hold is either driven directly or fed back from
    // at_max to form the saturating timer.
    logic       reset4, man_hold4, sat4, hold4, at_max4;
    logic [3:0] cntr4;
    assign hold4 = sat4 ? at_max4 : man_hold4;

    // size = 3 instance
    logic       reset3, hold3, at_max3;
    logic [2:0] cntr3;

    // size = 1 instance
    logic       reset1, hold1, at_max1;
    logic [0:0] cntr1;

    hold_counter #(.size(4)) dut4 (
        .clock (clock),
        .reset (reset4),
        .hold  (hold4),
        .cntr  (cntr4),
        .at_max(at_max4)
    );

    hold_counter #(.size(3)) dut3 (
        .clock (clock),
        .reset (reset3),
        .hold  (hold3),
        .cntr  (cntr3),
        .at_max(at_max3)
    );

    hold_counter #(.size(1)) dut1 (
        .clock (clock),
        .reset (reset1),
        .hold  (hold1),
        .cntr  (cntr1),
        .at_max(at_max1)
    );

    typedef struct {
        logic [31:0] cntr;
        logic        max;
    } exp_t;

    typedef struct {
        logic       hold;
        logic [3:0] cntr;
        logic       max;
    } vec_t;

    // Scoreboards: expectations are pushed when the stimulus for the next
    // edge is applied and popped just after that edge.
    exp_t q4[$];
    exp_t q3[$];
    exp_t q1[$];

    vec_t vecs[25];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input int v, input int sz);
        exp_t e;
        e.cntr = 32'(v);
        e.max  = (v == (1 << sz) - 1);
        return e;
    endfunction

    // Advance one rising edge, then compare every instance that has an
    // outstanding expectation, sampling 1 time unit after the edge.
    task automatic tick();
        exp_t e;
        @(posedge clock);
        #1;
        if (q4.size() > 0) begin
            e = q4.pop_front();
            check("cntr4", 32'(cntr4), e.cntr);
            check("at_max4", 32'(at_max4), 32'(e.max));
        end
        if (q3.size() > 0) begin
            e = q3.pop_front();
            check("cntr3", 32'(cntr3), e.cntr);
            check("at_max3", 32'(at_max3), 32'(e.max));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("cntr1", 32'(cntr1), e.cntr);
            check("at_max1", 32'(at_max1), 32'(e.max));
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        exp_t e;

        // Vector table for size = 4: free count 1..15 then wrap to 0,
        // followed by a hold window and a run up to 7.
        for (int i = 0; i < 16; i++) begin
            vecs[i].hold = 1'b0;
            vecs[i].cntr = 4'(i + 1);
            vecs[i].max  = (i == 14);
        end
        vecs[16] = '{1'b0, 4'd1, 1'b0};
        vecs[17] = '{1'b0, 4'd2, 1'b0};
        vecs[18] = '{1'b1, 4'd2, 1'b0};
        vecs[19] = '{1'b1, 4'd2, 1'b0};
        vecs[20] = '{1'b0, 4'd3, 1'b0};
        vecs[21] = '{1'b0, 4'd4, 1'b0};
        vecs[22] = '{1'b0, 4'd5, 1'b0};
        vecs[23] = '{1'b0, 4'd6, 1'b0};
        vecs[24] = '{1'b0, 4'd7, 1'b0};

        reset4    = 1'b0;
        reset3    = 1'b0;
        reset1    = 1'b0;
        man_hold4 = 1'b0;
        sat4      = 1'b0;
        hold3     = 1'b0;
        hold1     = 1'b0;

        // Reset state before any clock edge.
        #2;
        check("rst_cntr4", 32'(cntr4), 32'd0);
        check("rst_max4", 32'(at_max4), 32'd0);
        check("rst_cntr3", 32'(cntr3), 32'd0);
        check("rst_cntr1", 32'(cntr1), 32'd0);

        // Reset held low across edges keeps everything at 0.
        for (int i = 0; i < 2; i++) begin
            q4.push_back(mk(0, 4));
            q3.push_back(mk(0, 3));
            q1.push_back(mk(0, 1));
            tick();
        end

        // Release size-4 reset mid-cycle and run the vector table.
        #3;
        reset4 = 1'b1;
        for (int i = 0; i < 25; i++) begin
            man_hold4 = vecs[i].hold;
            e.cntr    = 32'(vecs[i].cntr);
            e.max     = vecs[i].max;
            q4.push_back(e);
            tick();
        end

        // Asynchronous reset mid-cycle with cntr at 7.
        #3;
        reset4 = 1'b0;
        #1;
        check("async_rst_cntr4", 32'(cntr4), 32'd0);
        check("async_rst_max4", 32'(at_max4), 32'd0);
        for (int i = 0; i < 2; i++) begin
            q4.push_back(mk(0, 4));
            tick();
        end

        // Saturating timer: hold = at_max. 15 edges to all ones, then stuck.
        #3;
        sat4   = 1'b1;
        reset4 = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            q4.push_back(mk(i, 4));
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            q4.push_back(mk(15, 4));
            tick();
        end

        // Restart: pulse reset low while saturated, release mid-cycle.
        #3;
        reset4 = 1'b0;
        #1;
        check("restart_cntr4", 32'(cntr4), 32'd0);
        check("restart_max4", 32'(at_max4), 32'd0);
        #1;
        reset4 = 1'b1;
        #1;
        check("restart_hold0", 32'(cntr4), 32'd0);
        q4.push_back(mk(1, 4));
        tick();

        // Glitches on hold between edges have no effect.
        sat4      = 1'b0;
        man_hold4 = 1'b0;
        #2 man_hold4 = 1'b1;
        #2 man_hold4 = 1'b0;
        q4.push_back(mk(2, 4));
        tick();
        man_hold4 = 1'b1;
        #2 man_hold4 = 1'b0;
        #2 man_hold4 = 1'b1;
        q4.push_back(mk(2, 4));
        tick();
        man_hold4 = 1'b0;

        // size = 3: count to 5, hold for 4 edges, resume, reach 7, wrap.
        #3;
        reset3 = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            q3.push_back(mk(i, 3));
            tick();
        end
        hold3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            q3.push_back(mk(5, 3));
            tick();
        end
        hold3 = 1'b0;
        q3.push_back(mk(6, 3));
        tick();
        q3.push_back(mk(7, 3));
        tick();
        q3.push_back(mk(0, 3));
        tick();

        // size = 1: toggles, at_max mirrors cntr.
        #3;
        reset1 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            q1.push_back(mk(i % 2, 1));
            tick();
        end

        check("q4_drained", 32'(q4.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
